odd_seq_checker: RTL
====================

// Module: odd_seq_checker
// PURPOSE
//  Downstream monitor for the odd counter. Samples its count output every qualified cycle.
//  Checks that the stream follows the odd sequence 1,3,5,...,15,1 (prev+2, modulo 2^WIDTH).
//  Reports lock status, sequence errors, a saturating error tally and target-value hits.
//  Sits between the odd counter and any logic that trusts its count.
// PARAMETERS
//  WIDTH   4  width of the monitored count
//  ERR_W   8  width of the saturating error counter
//  LOCK_N  3  consecutive correct +2 steps required to declare lock (>=1)
// PORTS
//  clk            in   1      system clock, all logic on rising edge
//  reset          in   1      synchronous, active-high; clears all state and outputs
//  count_in       in   WIDTH  count value from the odd counter
//  count_valid    in   1      count_in is sampled only in cycles where this is 1
//  upstream_reset in   1      the odd counter is being reset this cycle (resync request)
//  clr_err        in   1      synchronous clear of err_count
//  target         in   WIDTH  value that raises target_hit while locked
//  locked         out  1      sequence tracked and verified
//  seq_err        out  1      one-cycle pulse: a bad sample broke lock
//  err_count      out  ERR_W  number of lock-breaking errors, saturating
//  target_hit     out  1      one-cycle pulse: locked and sample == target
//  last_sample    out  WIDTH  most recent accepted sample
// BEHAVIOUR
//  - Reset values: all outputs 0; state IDLE; good_run=0; prev=0.
//  - All outputs are registered. A sample taken at edge N is reflected at edge N+1 (latency 1).
//  - nxt = prev + 2, truncated to WIDTH bits, so 15 -> 1 wraps legally.
//  - "odd" means count_in[0] == 1.
//  - count_valid=0: hold all state; seq_err and target_hit are 0.
//  - Priority: reset > upstream_reset > count_valid.
//  - upstream_reset=1:
//    - go to IDLE and set locked=0.
//    - seq_err stays 0; err_count is unchanged.
//    - count_in is ignored that cycle.
//  - FSM (evaluated only when count_valid=1):
//    - IDLE:
//      - odd sample: -> SYNC, prev=s, good_run=0.
//      - even sample: stay in IDLE; no error.
//    - SYNC, s == nxt:
//      - good_run += 1 and prev = s.
//      - if good_run reaches LOCK_N: -> LOCKED and locked=1.
//    - SYNC, s != nxt:
//      - good_run=0; no error.
//      - odd s: stay in SYNC with prev=s.
//      - even s: -> IDLE.
//    - LOCKED, s == nxt: stay; prev=s.
//    - LOCKED, s != nxt:
//      - seq_err=1 and err_count += 1 (saturating); locked=0.
//      - odd s: -> SYNC with prev=s and good_run=0.
//      - even s: -> IDLE.
//  - last_sample updates on every valid sample, in any state.
//  - target_hit=1 iff state was LOCKED, s == nxt and s == target.
//  - err_count:
//    - saturates at 2^ERR_W-1.
//    - clr_err forces 0; clr_err beats a simultaneous increment.
//    - cleared by reset; not cleared by upstream_reset.
//  - Mid-operation reset: same as the power-up reset; the next sample is handled as the first one.
// STRUCTURE
//  - Shared include odd_chk_defs.vh holds:
//    - state encodings ST_IDLE=2'd0, ST_SYNC=2'd1, ST_LOCKED=2'd2;
//    - a function next_odd(prev) returning prev+2 mod 2^WIDTH.
//  - One sub-module, sat_counter #(ERR_W), with ports clk, reset, inc, clr and cnt.
//    It implements the saturating increment and clear-priority rule.
//  - Top level holds the FSM, good_run (clog2(LOCK_N+1) bits), prev, and the output registers.
// TESTING
//  1. Reset, then valid samples 1,3,5,7 on consecutive cycles.
//     -> locked=1 one cycle after the 7 is sampled; err_count=0; last_sample=7.
//  2. Locked, target=1, samples 13,15,1,3.
//     -> locked stays 1; seq_err never asserts.
//     -> target_hit=1 exactly one cycle after the 1 is sampled.
//  3. Locked at 5, then sample 9.
//     -> seq_err pulses once; err_count=1; locked=0.
//     -> then 11,13,15: locked=1 after the 15.
//  4. Locked at 5, then sample 6.
//     -> seq_err=1, err_count+1, state IDLE.
//     -> then 1,3,5,7 relocks with no further error.
//  5. Locked at 5; upstream_reset=1 with count_in=5; then 1,3,5,7.
//     -> locked=0 and no seq_err; err_count unchanged.
//     -> relock after the 7.
//  6. ERR_W=2: five lock-break errors -> err_count=3.
//     -> clr_err together with a 6th error: err_count=0 the next cycle.

Source files
------------

// File: rtl/odd_seq_checker_pkg.sv
// Shared definitions for the odd-sequence checker.
// State encodings and the expected-successor function.
package odd_seq_checker_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Caller truncates to its own width, so 15 -> 1 wraps for WIDTH=4.
    function automatic logic [31:0] next_odd(input logic [31:0] prev);
        return prev + 32'd2;
    endfunction

endpackage

// File: rtl/odd_seq_checker_sat_counter.sv
// Saturating event counter with a clear that beats increment.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/odd_seq_checker.sv
// Monitors the odd counter stream (1,3,...,15,1) and reports
// lock, break errors, a saturating error tally and target hits.
module odd_seq_checker
    import odd_seq_checker_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int LOCK_N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_valid,
    input  logic             upstream_reset,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] target,
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count,
    output logic             target_hit,
    output logic [WIDTH-1:0] last_sample
);

    localparam int RW = $clog2(LOCK_N + 1);

    logic [1:0]       state_q, state_d;
    logic [RW-1:0]    run_q, run_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             locked_q, locked_d;
    logic             seq_err_q, seq_err_d;
    logic             hit_q, hit_d;
    logic             err_inc;
    logic [WIDTH-1:0] nxt;
    logic [RW-1:0]    run_inc;
    logic             match;
    logic             odd;

    assign nxt     = WIDTH'(next_odd(32'(prev_q)));
    assign run_inc = run_q + 1'b1;
    assign match   = (count_in == nxt);
    assign odd     = count_in[0];

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        prev_d    = prev_q;
        last_d    = last_q;
        seq_err_d = 1'b0;
        hit_d     = 1'b0;
        err_inc   = 1'b0;
        if (upstream_reset) begin
            state_d = ST_IDLE;
        end else if (count_valid) begin
            last_d = count_in;
            unique case (state_q)
                ST_IDLE: begin
                    if (odd) begin
                        state_d = ST_SYNC;
                        prev_d  = count_in;
                        run_d   = '0;
                    end
                end
                ST_SYNC: begin
                    if (match) begin
                        prev_d = count_in;
                        run_d  = run_inc;
                        if (run_inc == RW'(LOCK_N)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        run_d = '0;
                        if (odd) begin
                            prev_d = count_in;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        prev_d = count_in;
                        hit_d  = (count_in == target);
                    end else begin
                        seq_err_d = 1'b1;
                        err_inc   = 1'b1;
                        run_d     = '0;
                        if (odd) begin
                            state_d = ST_SYNC;
                            prev_d  = count_in;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            run_q     <= '0;
            prev_q    <= '0;
            last_q    <= '0;
            locked_q  <= 1'b0;
            seq_err_q <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            prev_q    <= prev_d;
            last_q    <= last_d;
            locked_q  <= locked_d;
            seq_err_q <= seq_err_d;
            hit_q     <= hit_d;
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (err_inc),
        .clr  (clr_err),
        .cnt  (err_count)
    );

    assign locked      = locked_q;
    assign seq_err     = seq_err_q;
    assign target_hit  = hit_q;
    assign last_sample = last_q;

endmodule
